// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lends one buffered UART transmitter to NUM_REQ byte-stream
// clients, one whole message per grant, pacing single-cycle tx_en strobes against tx_busy.
module uart_tx_arb #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_en,
  input  logic                 tx_busy,
  output logic                 arb_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W  = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0]    BURST_LAST = BC_W'(MAX_BURST - 1);
  localparam logic [7:0]         IDLE_LAST  = 8'(IDLE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   LAST_RST   = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   last, last_nxt;
  logic [BC_W-1:0]    burst_cnt, burst_cnt_nxt;
  logic [7:0]         idle_cnt, idle_cnt_nxt;
  logic               rel_q, rel_nxt;
  logic               hold_cnt, hold_cnt_nxt;
  logic [7:0]         tx_data_nxt;
  logic               tx_en_nxt;

  logic [IDX_W-1:0]   pick;
  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;
  logic               handshake;

  // First valid index strictly after 'from', wrapping; scanned backwards so the
  // nearest candidate in rotation order is the one that sticks.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDX_W-1:0]   from);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] ci;
    sel = from;
    for (int k = NUM_REQ; k >= 1; k--) begin
      ci = IDX_W'((int'(from) + k) % NUM_REQ);
      if (v[ci]) sel = ci;
    end
    return sel;
  endfunction

  assign pick = rr_pick(req_valid, last);

  // 'last' doubles as the owner index while a grant is held.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last == IDX_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  assign req_ready = (state == S_SEND && !tx_busy) ? grant : '0;
  assign handshake = (state == S_SEND) && !tx_busy && own_valid;
  assign arb_busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      grant     <= '0;
      last      <= LAST_RST;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      rel_q     <= 1'b0;
      hold_cnt  <= 1'b0;
      tx_data   <= 8'h00;
      tx_en     <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
      rel_q     <= rel_nxt;
      hold_cnt  <= hold_cnt_nxt;
      tx_data   <= tx_data_nxt;
      tx_en     <= tx_en_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    last_nxt      = last;
    burst_cnt_nxt = burst_cnt;
    idle_cnt_nxt  = idle_cnt;
    rel_nxt       = rel_q;
    hold_cnt_nxt  = hold_cnt;
    tx_data_nxt   = tx_data;
    tx_en_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          grant_nxt     = ONE_HOT0 << pick;
          last_nxt      = pick;
          burst_cnt_nxt = '0;
          idle_cnt_nxt  = 8'h00;
          state_nxt     = S_SEND;
        end
      end
      S_SEND: begin
        if (handshake) begin
          tx_data_nxt   = own_data;
          tx_en_nxt     = 1'b1;
          burst_cnt_nxt = burst_cnt + 1'b1;
          idle_cnt_nxt  = 8'h00;
          rel_nxt       = own_last | (burst_cnt == BURST_LAST);
          hold_cnt_nxt  = 1'b0;
          state_nxt     = S_HOLD;
        end else if (!own_valid) begin
          // A busy stall with valid held high never counts toward the timeout.
          if (idle_cnt == IDLE_LAST) begin
            grant_nxt = '0;
            state_nxt = S_IDLE;
          end else begin
            idle_cnt_nxt = idle_cnt + 8'd1;
          end
        end
      end
      S_HOLD: begin
        hold_cnt_nxt = 1'b1;
        if (hold_cnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (rel_q) begin
            grant_nxt = '0;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_SEND;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-client byte queues drive the requesters and a
// countdown model stands in for the UART busy flag.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int IT = 8;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_en;
  logic           tx_busy;
  logic           arb_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_busy   (tx_busy),
    .arb_busy  (arb_busy)
  );

  // UART model: busy for busy_len cycles starting the cycle after a tx_en strobe.
  int   busy_len   = 5;
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn)           busy_cnt <= 0;
    else if (tx_en)        busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  // Client queues: {last, data}; heads pop after an observed handshake.
  logic [8:0] cbuf [N][16];
  int         ch [N];
  int         ct [N];
  logic [N-1:0] hs_mask;

  initial begin
    for (int i = 0; i < N; i++) begin ch[i] = 0; ct[i] = 0; end
    hs_mask = '0; req_valid = '0; req_last = '0; req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (hs_mask[i] && ch[i] < ct[i]) ch[i]++;
      for (int i = 0; i < N; i++) begin
        if (ch[i] < ct[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = cbuf[i][ch[i]][7:0];
          req_last[i]        = cbuf[i][ch[i]][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      #1;
      hs_mask = req_valid & req_ready;
    end
  end

  logic [7:0]   log_d [64];
  logic [N-1:0] log_g [64];
  int           nlog = 0;
  initial forever begin
    @(negedge clk);
    if (resetn === 1'b1 && tx_en === 1'b1 && nlog < 64) begin
      log_d[nlog] = tx_data;
      log_g[nlog] = grant;
      nlog++;
    end
  end

  task automatic push(input int c, input logic [7:0] d, input logic l);
    cbuf[c][ct[c]] = {l, d};
    ct[c]++;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin ch[i] = 0; ct[i] = 0; end
    hs_mask = '0;
  endtask

  function automatic logic queues_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (ch[i] < ct[i]) e = 1'b0;
    return e;
  endfunction

  task automatic wait_done(input int maxc, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk); #1;
      if (!arb_busy && queues_empty() && busy_cnt == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    resetn = 1'b0;
    clear_queues();
    force_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_arb_busy: got %b want 0", arb_busy); end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    logic       ok;
    int         gbad;
    logic [7:0] ed [3];
    ed = '{8'h41, 8'h42, 8'h43};
    gbad = 0;
    busy_len = 40;
    @(posedge clk); #1;
    nlog = 0;
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant_latency: got %b want 0010", grant); end
    @(posedge clk); #1;
    checks++; if (tx_en !== 1'b1 || tx_data !== 8'h41) begin
      errors++; $display("FAIL single_first_strobe: got tx_en %b data %h want 1 41", tx_en, tx_data);
    end
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if (arb_busy && grant !== 4'b0010) gbad++;
      if (!arb_busy && queues_empty() && busy_cnt == 0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_done: timed out got 0 want 1"); end
    checks++; if (gbad != 0) begin errors++; $display("FAIL single_grant_held: got %0d bad cycles want 0", gbad); end
    checks++; if (nlog != 3) begin errors++; $display("FAIL single_count: got %0d want 3", nlog); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_d[i] !== ed[i] || log_g[i] !== 4'b0010) begin
        errors++; $display("FAIL single_byte%0d: got %h/%b want %h/0010", i, log_d[i], log_g[i], ed[i]);
      end
    end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b want 0000", grant); end
    busy_len = 5;
  endtask

  task automatic test_fairness();
    logic         ok;
    logic [7:0]   ed [3][4];
    logic [N-1:0] eg [3][4];
    ed[0] = '{8'hA0, 8'hA1, 8'hC0, 8'hC1};
    ed[1] = '{8'hA2, 8'hA3, 8'hC2, 8'hC3};
    ed[2] = '{8'hD0, 8'hD1, 8'hB0, 8'hB1};
    eg[0] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100};
    eg[1] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100};
    eg[2] = '{4'b1000, 4'b1000, 4'b0010, 4'b0010};
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      nlog = 0;
      case (r)
        0: begin push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1); push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1); end
        1: begin push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1); push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b1); end
        default: begin push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1); push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b1); end
      endcase
      wait_done(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fair_done%0d: timed out got 0 want 1", r); end
      checks++; if (nlog != 4) begin errors++; $display("FAIL fair_count%0d: got %0d want 4", r, nlog); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_d[i] !== ed[r][i] || log_g[i] !== eg[r][i]) begin
          errors++; $display("FAIL fair_r%0d_b%0d: got %h/%b want %h/%b", r, i, log_d[i], log_g[i], ed[r][i], eg[r][i]);
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    logic         ok;
    logic [7:0]   ed [8];
    logic [N-1:0] eg [8];
    ed = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h50, 8'h51, 8'h34, 8'h35};
    eg = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
    nlog = 0;
    for (int i = 0; i < 6; i++) push(3, 8'h30 + 8'(i), 1'b0);
    push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b1);
    wait_done(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_done: timed out got 0 want 1"); end
    checks++; if (nlog != 8) begin errors++; $display("FAIL burst_count: got %0d want 8", nlog); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_d[i] !== ed[i] || log_g[i] !== eg[i]) begin
        errors++; $display("FAIL burst_b%0d: got %h/%b want %h/%b", i, log_d[i], log_g[i], ed[i], eg[i]);
      end
    end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL burst_release: got %b want 0000", grant); end
  endtask

  task automatic test_idle_timeout();
    logic ok;
    int   kc;
    nlog = 0;
    push(0, 8'h60, 1'b0);
    push(1, 8'h70, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (tx_en === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL idle_strobe: timed out got 0 want 1"); end
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (req_ready[0] === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL idle_resend: timed out got 0 want 1"); end
    kc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (grant !== 4'b0001) begin kc = k; break; end
    end
    checks++; if (kc != 8 || grant !== 4'b0000) begin
      errors++; $display("FAIL idle_revoke: got %0d cycles grant %b want 8 cycles grant 0000", kc, grant);
    end
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL idle_next_grant: got %b want 0010", grant); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL idle_done: timed out got 0 want 1"); end
    checks++; if (nlog != 2 || log_d[0] !== 8'h60 || log_g[0] !== 4'b0001 || log_d[1] !== 8'h70 || log_g[1] !== 4'b0010) begin
      errors++; $display("FAIL idle_log: got n=%0d %h/%b %h/%b want n=2 60/0001 70/0010", nlog, log_d[0], log_g[0], log_d[1], log_g[1]);
    end
  endtask

  task automatic test_busy_stall();
    logic ok;
    int   rbad, tbad, gbad;
    rbad = 0; tbad = 0; gbad = 0;
    nlog = 0;
    force_busy = 1'b1;
    push(2, 8'h80, 1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (req_ready !== 4'b0000) rbad++;
      if (tx_en !== 1'b0) tbad++;
      if (grant !== 4'b0100) gbad++;
    end
    checks++; if (rbad != 0) begin errors++; $display("FAIL stall_ready: got %0d cycles want 0", rbad); end
    checks++; if (tbad != 0) begin errors++; $display("FAIL stall_tx_en: got %0d cycles want 0", tbad); end
    checks++; if (gbad != 0) begin errors++; $display("FAIL stall_grant: got %0d cycles want 0", gbad); end
    force_busy = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx_en !== 1'b1 || tx_data !== 8'h80) begin
      errors++; $display("FAIL stall_send: got tx_en %b data %h want 1 80", tx_en, tx_data);
    end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: timed out got 0 want 1"); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    push(0, 8'h90, 1'b0); push(0, 8'h91, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (tx_en === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || grant !== 4'b0001) begin
      errors++; $display("FAIL mid_strobe: got seen %b grant %b want 1 0001", ok, grant);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL mid_tx_en: got %b want 0", tx_en); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant: got %b want 0000", grant); end
    checks++; if (req_ready !== 4'b0000 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL mid_ready_busy: got %b/%b want 0000/0", req_ready, arb_busy);
    end
    clear_queues();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    nlog = 0;
    push(0, 8'hE0, 1'b1); push(1, 8'hE1, 1'b1);
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_first_arb: got %b want 0001", grant); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_done: timed out got 0 want 1"); end
    checks++; if (nlog != 2 || log_d[0] !== 8'hE0 || log_g[0] !== 4'b0001 || log_d[1] !== 8'hE1 || log_g[1] !== 4'b0010) begin
      errors++; $display("FAIL mid_log: got n=%0d %h/%b %h/%b want n=2 e0/0001 e1/0010", nlog, log_d[0], log_g[0], log_d[1], log_g[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst_cap();
    test_idle_timeout();
    test_busy_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one buffered UART transmitter among `NUM_REQ` byte-stream clients. It grants the transmitter to one client for a whole message, terminated by `req_last`, a `MAX_BURST` byte cap, or an idle timeout. It paces single-byte `tx_en` pulses against the transmitter's `tx_busy` flag. It sits between the debug/console clients and the UART TX buffer, and drives that block's `tx_data`/`tx_en` inputs directly.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 16: maximum bytes per grant before forced release, 1..255.
- `IDLE_TIMEOUT`, default 64: cycles the grant holder may leave `req_valid` low before its grant is revoked, 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-client byte available.
- `req_data`  in  8*NUM_REQ  per-client byte; client i uses bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the final byte of the message; qualified by valid.
- `req_ready`  out  NUM_REQ  combinational; byte accepted when valid&ready.
- `grant`  out  NUM_REQ  registered one-hot owner, or all zero.
- `tx_data`  out  8  registered byte to the UART.
- `tx_en`  out  1  registered one-cycle send strobe.
- `tx_busy`  in  1  UART busy flag.
- `arb_busy`  out  1  state != IDLE.

## Operation
- State machine: IDLE, SEND, HOLD, WAIT.
- **IDLE:**
  - If any `req_valid`, select the first valid index scanning from `last+1` upward, wrapping modulo NUM_REQ.
  - Register the selection in `grant` and `last`, clear `burst_cnt` and `idle_cnt`, and go to SEND.
  - If no requester is valid, stay in IDLE.
- **SEND:**
  - `req_ready[i] = grant[i] & ~tx_busy`. All other ready bits are 0.
  - On handshake:
    - `tx_data <= byte`, `tx_en <= 1`, `burst_cnt++`, `idle_cnt <= 0`.
    - `release <= req_last | (burst_cnt == MAX_BURST-1)`.
    - Go to HOLD.
  - If the granted requester's valid is low, `idle_cnt++`. When `idle_cnt == IDLE_TIMEOUT-1`, clear `grant` and go to IDLE.
  - If valid is high but `tx_busy` is high, stall; `idle_cnt` does not advance.
- **HOLD:**
  - Lasts exactly 2 cycles, covering the UART's input register and latch delay.
  - `tx_en` is cleared after its first cycle.
  - `req_ready` is 0.
  - Then go to WAIT.
- **WAIT:**
  - `req_ready` is 0.
  - When `tx_busy == 0`: if `release`, clear `grant` and go to IDLE; otherwise go to SEND.
- Other requesters' valid bits are ignored while a grant is held, so there is no preemption.
- `burst_cnt` is $clog2(MAX_BURST+1) bits and `idle_cnt` is 8 bits. Neither wraps: both are cleared on every grant.

## Timing
- Reset values while `resetn` is low, applied immediately and asynchronously:
  - `grant=0`, `tx_en=0`, `tx_data=0`, `req_ready=0`, `arb_busy=0`.
  - State IDLE, `last=NUM_REQ-1`, so client 0 wins the first arbitration.
- Reset mid-message drops the message. `tx_en` falls without waiting for a clock, and no partial state survives.
- Arbitration latency: valid in IDLE at cycle T gives `grant` at T+1 and earliest handshake at T+1.
- Handshake at edge T gives `tx_en=1` during T+1 only. HOLD occupies T+1 and T+2, and WAIT starts at T+3.
- Minimum spacing between `tx_en` pulses is 4 cycles plus the UART busy time.
- After release, IDLE spends 1 cycle before the next grant. Back-to-back messages therefore cost 1 extra cycle.
- A single-byte message (`req_last` on the first byte) releases after one byte.
- `req_last` together with hitting the burst cap gives a single release; no special case is needed.
- If the grant holder drops valid and re-asserts it on the cycle the timeout fires, the timeout wins. That client re-arbitrates from IDLE at the lowest rotation priority.

## Test plan
- **Single message:** client 1 sends 0x41, 0x42, 0x43 with `req_last` on 0x43, `tx_busy` modelled as 40 cycles per byte.
  - Required: three `tx_en` pulses with data 0x41/0x42/0x43 in order.
  - Required: `grant=4'b0010` throughout, then 0.
- **Fairness:** clients 0 and 2 both hold 2-byte messages from reset.
  - Required: client 0 is served fully, then client 2.
  - Required: a second pair of simultaneous requests serves client 0 after client 2 only because the rotation points past 2.
- **Burst cap:** with MAX_BURST=4, client 3 streams 6 bytes and never asserts last, while client 0 is also valid.
  - Required: 4 bytes from client 3, then client 0's message, then client 3's remaining 2 bytes.
- **Idle timeout:** with IDLE_TIMEOUT=8, client 0 sends 1 byte without last, then drops valid.
  - Required: `grant` clears exactly 8 cycles after SEND is re-entered.
  - Required: client 1, pending, is granted the next cycle.
- **Busy stall:** force `tx_busy=1` for 100 cycles while client 2 is granted and valid.
  - Required: `req_ready=0` and no `tx_en` during the stall.
  - Required: no timeout.
  - Required: the byte is sent on the first non-busy cycle.
- **Reset mid-message:** assert `resetn=0` during HOLD.
  - Required: `tx_en`, `grant` and `req_ready` go 0 immediately.
  - Required: after release, client 0 wins first arbitration.
